// File: rtl/request_mux_reg.sv
// rtl/request_mux_reg.sv - N-to-1 request selector with registered copy; optional REQUEST_MUX_SEL_CHECK_EN sticky select_err
module request_mux_reg #(
    parameter  int REQ_WIDTH  = 14,
    parameter  int REQ_NUMBER = 2,
    localparam int SEL_WIDTH  = (REQ_NUMBER > 1) ? $clog2(REQ_NUMBER) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REQ_WIDTH-1:0] requests [REQ_NUMBER],
    input  logic [SEL_WIDTH-1:0] select,
    output logic [REQ_WIDTH-1:0] selected_request,
    output logic                 selected_valid,
    output logic [REQ_WIDTH-1:0] selected_request_q,
    output logic                 select_err
);

    logic [31:0]          w_sel_ext;
    logic [REQ_WIDTH-1:0] w_selected;
    logic [REQ_WIDTH-1:0] r_selected_q;

    assign w_sel_ext = 32'(select);

    // An out-of-range select matches no index and yields all-zero: not valid, wr=0.
    always_comb begin
        w_selected = '0;
        for (int i = 0; i < REQ_NUMBER; i++) begin
            if (w_sel_ext == 32'(i)) begin
                w_selected = requests[i];
            end
        end
    end

    assign selected_request = w_selected;
    assign selected_valid   = w_selected[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_selected_q <= '0;
        end else begin
            r_selected_q <= w_selected;
        end
    end

    assign selected_request_q = r_selected_q;

`ifdef REQUEST_MUX_SEL_CHECK_EN
    logic w_out_of_range;
    logic r_select_err;

    assign w_out_of_range = (w_sel_ext >= 32'(REQ_NUMBER));

    // Sticky until reset; reset dominates a simultaneous out-of-range select.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_select_err <= 1'b0;
        end else if (w_out_of_range) begin
            r_select_err <= 1'b1;
        end
    end

    assign select_err = r_select_err;
`else
    assign select_err = 1'b0;
`endif

endmodule

// File: tb/tb_request_mux_reg.sv
// tb/tb_request_mux_reg.sv - scoreboard bench for request_mux_reg at REQ_NUMBER 2, 3 and 1
module tb_request_mux_reg;

`ifdef REQUEST_MUX_SEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [13:0] req2 [2];
    logic [0:0]  sel2;
    logic [13:0] sr2, q2;
    logic        v2, err2;

    logic [13:0] req3 [3];
    logic [1:0]  sel3;
    logic [13:0] sr3, q3;
    logic        v3, err3;

    logic [13:0] req1 [1];
    logic [0:0]  sel1;
    logic [13:0] sr1, q1;
    logic        v1, err1;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    request_mux_reg #(.REQ_WIDTH(14), .REQ_NUMBER(2)) u_dut2 (
        .clk(clk), .reset(reset), .requests(req2), .select(sel2),
        .selected_request(sr2), .selected_valid(v2),
        .selected_request_q(q2), .select_err(err2)
    );

    request_mux_reg #(.REQ_WIDTH(14), .REQ_NUMBER(3)) u_dut3 (
        .clk(clk), .reset(reset), .requests(req3), .select(sel3),
        .selected_request(sr3), .selected_valid(v3),
        .selected_request_q(q3), .select_err(err3)
    );

    request_mux_reg #(.REQ_WIDTH(14), .REQ_NUMBER(1)) u_dut1 (
        .clk(clk), .reset(reset), .requests(req1), .select(sel1),
        .selected_request(sr1), .selected_valid(v1),
        .selected_request_q(q1), .select_err(err1)
    );

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        req2[0] = 14'h1235; req2[1] = 14'h0ABC; sel2 = 1'b0;
        req3[0] = 14'h1111; req3[1] = 14'h2223; req3[2] = 14'h3335; sel3 = 2'd0;
        req1[0] = 14'h3FFF; sel1 = 1'b0;

        // reset state and combinational path during reset
        #1;
        expect_val("rst_q2", 32'h0);      compare(32'(q2));
        expect_val("rst_q3", 32'h0);      compare(32'(q3));
        expect_val("rst_q1", 32'h0);      compare(32'(q1));
        expect_val("rst_err3", 32'h0);    compare(32'(err3));
        expect_val("rst_comb2", 32'h1235); compare(32'(sr2));

        @(negedge clk);
        reset = 1'b1;
        expect_val("first_load_q2", 32'h1235);
        @(posedge clk); #1;
        compare(32'(q2));

        // same-cycle selection
        @(negedge clk);
        expect_val("sel0_req", 32'h1235); compare(32'(sr2));
        expect_val("sel0_valid", 32'h1);  compare(32'(v2));
        sel2 = 1'b1; #1;
        expect_val("sel1_req", 32'h0ABC); compare(32'(sr2));
        expect_val("sel1_valid", 32'h0);  compare(32'(v2));

        // registered copy lags by exactly one edge
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel2 = 1'(i);
            #1;
            expect_val("lag_before_edge", (i % 2 == 0) ? 32'h0ABC : 32'h1235);
            compare(32'(q2));
            expect_val("lag_after_edge", (i % 2 == 0) ? 32'h1235 : 32'h0ABC);
            @(posedge clk); #1;
            compare(32'(q2));
        end

        // out-of-range select on REQ_NUMBER=3
        @(negedge clk);
        sel3 = 2'd3; #1;
        expect_val("oor_req", 32'h0);   compare(32'(sr3));
        expect_val("oor_valid", 32'h0); compare(32'(v3));
        @(posedge clk); #1;
        expect_val("oor_q", 32'h0);           compare(32'(q3));
        expect_val("oor_err_set", 32'(CHK));  compare(32'(err3));
        @(negedge clk);
        sel3 = 2'd0; #1;
        expect_val("n3_sel0", 32'h1111); compare(32'(sr3));
        @(posedge clk); #1;
        expect_val("oor_err_sticky", 32'(CHK)); compare(32'(err3));

        // asynchronous reset between edges
        @(negedge clk);
        sel2 = 1'b0;
        @(posedge clk); #1;
        expect_val("pre_rst_q2", 32'h1235); compare(32'(q2));
        #2;
        reset = 1'b0;
        #1;
        expect_val("async_rst_q2", 32'h0);   compare(32'(q2));
        expect_val("async_rst_err3", 32'h0); compare(32'(err3));
        expect_val("rst_comb_follow", 32'h1235); compare(32'(sr2));

        // reset wins over a simultaneous out-of-range select
        sel3 = 2'd3;
        @(posedge clk); #1;
        expect_val("rst_wins_err3", 32'h0); compare(32'(err3));
        @(negedge clk);
        sel3 = 2'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        expect_val("post_rst_q2", 32'h1235); compare(32'(q2));
        expect_val("post_rst_err3", 32'h0);  compare(32'(err3));

        // REQ_NUMBER=1
        @(negedge clk);
        expect_val("n1_sel0", 32'h3FFF);  compare(32'(sr1));
        expect_val("n1_valid0", 32'h1);   compare(32'(v1));
        sel1 = 1'b1; #1;
        expect_val("n1_sel1", 32'h0);     compare(32'(sr1));
        expect_val("n1_valid1", 32'h0);   compare(32'(v1));
        @(posedge clk); #1;
        expect_val("n1_err", 32'(CHK));   compare(32'(err1));
        expect_val("n1_q", 32'h0);        compare(32'(q1));

        // combinational tracking of request change mid-cycle
        @(negedge clk);
        sel2 = 1'b1;
        req2[1] = 14'h0001; #1;
        expect_val("track_a", 32'h0001); compare(32'(sr2));
        expect_val("track_va", 32'h1);   compare(32'(v2));
        #2;
        req2[1] = 14'h2000; #1;
        expect_val("track_b", 32'h2000); compare(32'(sr2));
        expect_val("track_vb", 32'h0);   compare(32'(v2));
        expect_val("n2_err", 32'h0);     compare(32'(err2));

        if (sb.size() != 0) begin
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
